ham_minmax_ctrl: RTL

- Sequencer that runs the program-1 workload in hardware over the shared byte-wide data memory (`dm`).
- Input: N 16-bit words stored as byte pairs at mem[0 .. 2N-1].
- Finds the min and max Hamming distance over all pairs (j<k) and writes min to mem[64], max to mem[65].
- Sits beside the core in `top`, owns the dm port while busy, and uses the same start/done handshake as `top`.

---
 rtl/ham_pkg.sv | 20 ++
 rtl/ham_minmax_ctrl_if.sv | 32 +++
 rtl/ham_dist16.sv | 20 ++
 rtl/ham_minmax_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared types and constants for the Hamming min/max sequencer.
package ham_pkg;

  localparam int unsigned HAM_W = 5;
  localparam logic [HAM_W-1:0] HAM_INIT_MIN = 5'd16;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    WR_MIN,
    WR_MAX,
    WR_MINPAIR,
    WR_MAXPAIR,
    DONE
  } state_t;

endpackage

// File: rtl/ham_minmax_ctrl_if.sv
// Start/done handshake plus byte-wide dm port between the sequencer and its memory.
interface ham_minmax_ctrl_if;

  logic       start;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  modport master (
    input  start,
    input  mem_rdata,
    output done,
    output busy,
    output mem_addr,
    output mem_wr_en,
    output mem_wdata
  );

  modport slave (
    output start,
    output mem_rdata,
    input  done,
    input  busy,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata
  );

endinterface

// File: rtl/ham_dist16.sv
// Combinational Hamming distance of two 16-bit words (XOR + popcount, 0..16).
module ham_dist16
  import ham_pkg::*;
(
  input  word_t             i_a,
  input  word_t             i_b,
  output logic [HAM_W-1:0]  o_dist
);

  word_t w_x;

  always_comb begin
    w_x    = i_a ^ i_b;
    o_dist = '0;
    for (int i = 0; i < 16; i++) begin
      o_dist = o_dist + {4'b0, w_x[i]};
    end
  end

endmodule

// File: rtl/ham_minmax_ctrl.sv
// Min/max pairwise Hamming distance sequencer over dm; results at RES_ADDR/+1.
// Optional HAM_PAIR_ADDR_EN also writes winning (j,k) indices to RES_ADDR+2..+5.
module ham_minmax_ctrl
  import ham_pkg::*;
#(
  parameter int unsigned N_WORDS   = 32,
  parameter logic [7:0]  BASE_ADDR = 8'd0,
  parameter logic [7:0]  RES_ADDR  = 8'd64
) (
  input logic               clk,
  input logic               rst_n,
  ham_minmax_ctrl_if.master bus
);

  localparam logic [6:0] LOAD_LAST = 7'(2 * N_WORDS);
  localparam logic [4:0] J_LAST    = 5'(N_WORDS - 2);
  localparam logic [4:0] K_LAST    = 5'(N_WORDS - 1);

  state_t           r_state, w_state_next;
  logic             r_start_q;
  logic [6:0]       r_cnt;
  logic [4:0]       r_j, r_k;
  logic [HAM_W-1:0] r_min, r_max;
  logic [HAM_W-1:0] w_dist;
  word_t            r_buf [32];
  logic [5:0]       w_byte_idx;
  logic             w_launch, w_last_pair;
`ifdef HAM_PAIR_ADDR_EN
  logic [4:0]       r_min_j, r_min_k, r_max_j, r_max_k;
  logic             r_phase;
`endif

  assign w_launch    = (r_state == IDLE) && r_start_q && !bus.start;
  assign w_last_pair = (r_j == J_LAST) && (r_k == K_LAST);
  // Capture lags the issued address by one cycle.
  assign w_byte_idx  = 6'(r_cnt - 7'd1);

  ham_dist16 u_dist (
    .i_a    (r_buf[r_j]),
    .i_b    (r_buf[r_k]),
    .o_dist (w_dist)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:   if (w_launch) w_state_next = LOAD;
      LOAD: begin
        if (bus.start)                w_state_next = IDLE;
        else if (r_cnt == LOAD_LAST)  w_state_next = CMP;
      end
      CMP: begin
        if (bus.start)        w_state_next = IDLE;
        else if (w_last_pair) w_state_next = WR_MIN;
      end
      WR_MIN: w_state_next = WR_MAX;
`ifdef HAM_PAIR_ADDR_EN
      WR_MAX:     w_state_next = WR_MINPAIR;
      WR_MINPAIR: if (r_phase) w_state_next = WR_MAXPAIR;
      WR_MAXPAIR: if (r_phase) w_state_next = DONE;
`else
      WR_MAX: w_state_next = DONE;
`endif
      DONE:   if (bus.start) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.done      = 1'b0;
    bus.busy      = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (r_state)
      LOAD: begin
        bus.busy = 1'b1;
        if (r_cnt < LOAD_LAST) bus.mem_addr = BASE_ADDR + 8'(r_cnt);
      end
      CMP: bus.busy = 1'b1;
      WR_MIN: begin
        bus.busy      = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = RES_ADDR;
        bus.mem_wdata = {3'b0, r_min};
      end
      WR_MAX: begin
        bus.busy      = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = RES_ADDR + 8'd1;
        bus.mem_wdata = {3'b0, r_max};
      end
`ifdef HAM_PAIR_ADDR_EN
      WR_MINPAIR: begin
        bus.busy      = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = RES_ADDR + (r_phase ? 8'd3 : 8'd2);
        bus.mem_wdata = {3'b0, (r_phase ? r_min_k : r_min_j)};
      end
      WR_MAXPAIR: begin
        bus.busy      = 1'b1;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = RES_ADDR + (r_phase ? 8'd5 : 8'd4);
        bus.mem_wdata = {3'b0, (r_phase ? r_max_k : r_max_j)};
      end
`endif
      DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b1;
      r_cnt     <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_min     <= HAM_INIT_MIN;
      r_max     <= '0;
`ifdef HAM_PAIR_ADDR_EN
      r_min_j   <= '0;
      r_min_k   <= '0;
      r_max_j   <= '0;
      r_max_k   <= '0;
      r_phase   <= 1'b0;
`endif
    end else begin
      r_start_q <= bus.start;
      unique case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_cnt   <= '0;
            r_min   <= HAM_INIT_MIN;
            r_max   <= '0;
`ifdef HAM_PAIR_ADDR_EN
            r_min_j <= '0;
            r_min_k <= '0;
            r_max_j <= '0;
            r_max_k <= '0;
`endif
          end
        end
        LOAD: begin
          r_cnt <= r_cnt + 7'd1;
          r_j   <= 5'd0;
          r_k   <= 5'd1;
        end
        CMP: begin
          // Strict compares keep the first pair in scan order on ties.
          if (w_dist < r_min) begin
            r_min   <= w_dist;
`ifdef HAM_PAIR_ADDR_EN
            r_min_j <= r_j;
            r_min_k <= r_k;
`endif
          end
          if (w_dist > r_max) begin
            r_max   <= w_dist;
`ifdef HAM_PAIR_ADDR_EN
            r_max_j <= r_j;
            r_max_k <= r_k;
`endif
          end
          if (r_k == K_LAST) begin
            r_j <= r_j + 5'd1;
            r_k <= r_j + 5'd2;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end
`ifdef HAM_PAIR_ADDR_EN
        WR_MAX:                 r_phase <= 1'b0;
        WR_MINPAIR, WR_MAXPAIR: r_phase <= ~r_phase;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == LOAD && r_cnt != 7'd0) begin
      if (w_byte_idx[0]) r_buf[w_byte_idx[5:1]][7:0]  <= bus.mem_rdata;
      else               r_buf[w_byte_idx[5:1]][15:8] <= bus.mem_rdata;
    end
  end

endmodule
